// File: rtl/wb_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_pkg
// Brief    : Shared widths, load funct3 codes and source-select encoding for
//            the writeback/commit stage.
// Revision : 1.0
// ============================================================================
package wb_commit_pkg;

    localparam int unsigned c_XLEN       = 32;
    localparam int unsigned c_REG_NUM    = 32;
    localparam int unsigned c_REG_ADDR_W = 5;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_LSU  = 2'd2
    } wb_src_e;

endpackage : wb_commit_pkg
`default_nettype wire

// File: rtl/wb_commit_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_load_ext
// Brief    : Selects the addressed byte/half of an aligned memory word and
//            sign- or zero-extends it according to the load funct3.
// Revision : 1.0
// ============================================================================
module wb_commit_load_ext
    import wb_commit_pkg::*;
#(
    parameter int unsigned XLEN = c_XLEN
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_byte_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_byte_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halves are naturally aligned, so only off[1] picks the half.
        w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            c_F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule : wb_commit_load_ext
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Brief    : Writeback/commit stage: LSU-over-EX arbitration, registered
//            register-file write port and per-register busy scoreboard.
//            Optional same-cycle bypass enabled by macro WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int unsigned XLEN    = c_XLEN,
    parameter int unsigned REG_NUM = c_REG_NUM
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic                    ex_rd_we_i,
    input  logic [c_REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic [XLEN-1:0]         ex_rd_data_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [c_REG_ADDR_W-1:0] lsu_rd_addr_i,
    input  logic [2:0]              lsu_funct3_i,
    input  logic [1:0]              lsu_byte_off_i,
    input  logic [XLEN-1:0]         lsu_rdata_i,
    input  logic                    issue_we_i,
    input  logic [c_REG_ADDR_W-1:0] issue_rd_i,
    output logic [REG_NUM-1:0]      busy_o,
    output logic                    rd_we_o,
    output logic [c_REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]         rd_data_o,
    output logic                    fwd_valid_o,
    output logic [c_REG_ADDR_W-1:0] fwd_addr_o,
    output logic [XLEN-1:0]         fwd_data_o
);

    logic                    r_lsu_ready;
    logic                    r_rd_we;
    logic [c_REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]         r_rd_data;
    logic [REG_NUM-1:0]      r_busy;

    wb_src_e                 w_src;
    logic                    w_lsu_accept;
    logic                    w_ex_accept;
    logic                    w_accept;
    logic                    w_wb_we;
    logic [c_REG_ADDR_W-1:0] w_wb_addr;
    logic [XLEN-1:0]         w_wb_data;
    logic [XLEN-1:0]         w_load_data;
    logic [REG_NUM-1:0]      w_set;
    logic [REG_NUM-1:0]      w_clr;
    logic [REG_NUM-1:0]      w_busy_next;

    // ------------------------------------------------------------------
    // Arbitration: the LSU cannot be stalled, so it always wins.
    // ------------------------------------------------------------------
    assign ex_ready_o   = ~lsu_valid_i;
    assign lsu_ready_o  = r_lsu_ready;
    assign w_lsu_accept = lsu_valid_i & r_lsu_ready;
    assign w_ex_accept  = ex_valid_i & ex_ready_o;
    assign w_accept     = w_lsu_accept | w_ex_accept;

    always_comb begin
        w_src = SRC_NONE;
        if (w_lsu_accept) begin
            w_src = SRC_LSU;
        end else if (w_ex_accept) begin
            w_src = SRC_EX;
        end
    end

    wb_commit_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_funct3   (lsu_funct3_i),
        .i_byte_off (lsu_byte_off_i),
        .i_rdata    (lsu_rdata_i),
        .o_data     (w_load_data)
    );

    // Writes to x0 still complete the handshake but never reach the file.
    always_comb begin
        w_wb_we   = 1'b0;
        w_wb_addr = r_rd_addr;
        w_wb_data = r_rd_data;
        case (w_src)
            SRC_LSU: begin
                w_wb_we   = (lsu_rd_addr_i != '0);
                w_wb_addr = lsu_rd_addr_i;
                w_wb_data = w_load_data;
            end
            SRC_EX: begin
                w_wb_we   = ex_rd_we_i && (ex_rd_addr_i != '0);
                w_wb_addr = ex_rd_addr_i;
                w_wb_data = ex_rd_data_i;
            end
            default: begin
                w_wb_we   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered register-file write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lsu_ready <= 1'b0;
            r_rd_we     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_lsu_ready <= 1'b1;
            r_rd_we     <= w_wb_we;
            if (w_accept) begin
                r_rd_addr <= w_wb_addr;
                r_rd_data <= w_wb_data;
            end
        end
    end

    assign rd_we_o   = r_rd_we;
    assign rd_addr_o = r_rd_addr;
    assign rd_data_o = r_rd_data;

    // ------------------------------------------------------------------
    // Busy scoreboard: a new issue beats a retiring write to the same reg.
    // ------------------------------------------------------------------
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 1; i < int'(REG_NUM); i++) begin
            w_set[i] = issue_we_i && (issue_rd_i == c_REG_ADDR_W'(i));
            w_clr[i] = r_rd_we && (r_rd_addr == c_REG_ADDR_W'(i));
        end
        w_busy_next    = (r_busy & ~w_clr) | w_set;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign busy_o = r_busy;

`ifndef SYNTHESIS
    // Decode must not re-issue to a register whose write is still pending,
    // unless that write is retiring in this very cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && issue_we_i && (issue_rd_i != '0)) begin
            assert (!r_busy[issue_rd_i] || (r_rd_we && (r_rd_addr == issue_rd_i)));
        end
    end
`endif

    // ------------------------------------------------------------------
    // Optional bypass of the result being accepted this cycle
    // ------------------------------------------------------------------
`ifdef WB_BYPASS_EN
    assign fwd_valid_o = w_wb_we;
    assign fwd_addr_o  = w_wb_we ? w_wb_addr : '0;
    assign fwd_data_o  = w_wb_we ? w_wb_data : '0;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_addr_o  = '0;
    assign fwd_data_o  = '0;
`endif

endmodule : wb_commit
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit
// Brief    : Directed self-checking bench for wb_commit.
// Revision : 1.0
// ============================================================================
module tb_wb_commit;

    logic        clk;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_rd_we_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_rd_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [2:0]  lsu_funct3_i;
    logic [1:0]  lsu_byte_off_i;
    logic [31:0] lsu_rdata_i;
    logic        issue_we_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] busy_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;

    int n_tests;
    int n_fail;

    wb_commit dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_rd_we_i     (ex_rd_we_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_rd_data_i   (ex_rd_data_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_addr_i  (lsu_rd_addr_i),
        .lsu_funct3_i   (lsu_funct3_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .issue_we_i     (issue_we_i),
        .issue_rd_i     (issue_rd_i),
        .busy_o         (busy_o),
        .rd_we_o        (rd_we_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_o      (rd_data_o),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_addr_o     (fwd_addr_o),
        .fwd_data_o     (fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_issue(input logic [4:0] rd);
        @(negedge clk);
        issue_we_i = 1'b1;
        issue_rd_i = rd;
        @(posedge clk);
        #1;
        issue_we_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i          = 1'b1;
        ex_valid_i     = 1'b0;
        ex_rd_we_i     = 1'b0;
        ex_rd_addr_i   = '0;
        ex_rd_data_i   = '0;
        lsu_valid_i    = 1'b0;
        lsu_rd_addr_i  = '0;
        lsu_funct3_i   = '0;
        lsu_byte_off_i = '0;
        lsu_rdata_i    = '0;
        issue_we_i     = 1'b0;
        issue_rd_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rd_we_o !== 1'b0)      begin n_fail++; $display("FAIL reset_rd_we got %0b want 0", rd_we_o); end
        n_tests++; if (rd_addr_o !== 5'd0)    begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr_o); end
        n_tests++; if (rd_data_o !== 32'h0)   begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
        n_tests++; if (busy_o !== 32'h0)      begin n_fail++; $display("FAIL reset_busy got %h want 0", busy_o); end
        n_tests++; if (lsu_ready_o !== 1'b0)  begin n_fail++; $display("FAIL reset_lsu_ready got %0b want 0", lsu_ready_o); end
        n_tests++; if (fwd_valid_o !== 1'b0 || fwd_data_o !== 32'h0)
            begin n_fail++; $display("FAIL reset_fwd got %0b/%h want 0/0", fwd_valid_o, fwd_data_o); end
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (lsu_ready_o !== 1'b1)  begin n_fail++; $display("FAIL post_reset_lsu_ready got %0b want 1", lsu_ready_o); end
    endtask

    task automatic test_ex_commit;
        logic        exp_fv;
        logic [31:0] exp_fd;
        do_issue(5'd5);
        n_tests++; if (busy_o !== 32'h0000_0020) begin n_fail++; $display("FAIL ex_busy_set got %h want 00000020", busy_o); end
        @(negedge clk);
        ex_valid_i   = 1'b1;
        ex_rd_we_i   = 1'b1;
        ex_rd_addr_i = 5'd5;
        ex_rd_data_i = 32'h1234_5678;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL ex_ready got %0b want 1", ex_ready_o); end
`ifdef WB_BYPASS_EN
        exp_fv = 1'b1; exp_fd = 32'h1234_5678;
`else
        exp_fv = 1'b0; exp_fd = 32'h0;
`endif
        n_tests++; if (fwd_valid_o !== exp_fv || fwd_data_o !== exp_fd)
            begin n_fail++; $display("FAIL ex_fwd got %0b/%h want %0b/%h", fwd_valid_o, fwd_data_o, exp_fv, exp_fd); end
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        n_tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_data_o !== 32'h1234_5678)
            begin n_fail++; $display("FAIL ex_write got we=%0b a=%0d d=%h want 1/5/12345678", rd_we_o, rd_addr_o, rd_data_o); end
        n_tests++; if (busy_o !== 32'h0000_0020) begin n_fail++; $display("FAIL ex_busy_pending got %h want 00000020", busy_o); end
        @(posedge clk);
        #1;
        n_tests++; if (rd_we_o !== 1'b0) begin n_fail++; $display("FAIL ex_one_cycle got %0b want 0", rd_we_o); end
        n_tests++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL ex_busy_clear got %h want 0", busy_o); end
        n_tests++; if (rd_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL ex_hold got %h want 12345678", rd_data_o); end
    endtask

    task automatic test_arbitration;
        @(negedge clk);
        lsu_valid_i    = 1'b1;
        lsu_rd_addr_i  = 5'd3;
        lsu_funct3_i   = 3'b010;
        lsu_byte_off_i = 2'd0;
        lsu_rdata_i    = 32'hA5A5_0003;
        ex_valid_i     = 1'b1;
        ex_rd_we_i     = 1'b1;
        ex_rd_addr_i   = 5'd4;
        ex_rd_data_i   = 32'h0000_4444;
        #1;
        n_tests++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL arb_ex_ready got %0b want 0", ex_ready_o); end
        @(posedge clk);
        #1;
        lsu_valid_i = 1'b0;
        n_tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd3 || rd_data_o !== 32'hA5A5_0003)
            begin n_fail++; $display("FAIL arb_lsu_first got we=%0b a=%0d d=%h want 1/3/a5a50003", rd_we_o, rd_addr_o, rd_data_o); end
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL arb_ex_ready_release got %0b want 1", ex_ready_o); end
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        n_tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd4 || rd_data_o !== 32'h0000_4444)
            begin n_fail++; $display("FAIL arb_ex_second got we=%0b a=%0d d=%h want 1/4/00004444", rd_we_o, rd_addr_o, rd_data_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [1:0]  off [6] = '{2'd3,   2'd3,   2'd2,   2'd0,   2'd3,   2'd1};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        logic        exp_fv;
        logic [31:0] exp_fd;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lsu_valid_i    = 1'b1;
            lsu_rd_addr_i  = 5'(10 + i);
            lsu_funct3_i   = f3[i];
            lsu_byte_off_i = off[i];
            lsu_rdata_i    = 32'h80FF_7F01;
            #1;
`ifdef WB_BYPASS_EN
            exp_fv = 1'b1; exp_fd = exp[i];
`else
            exp_fv = 1'b0; exp_fd = 32'h0;
`endif
            n_tests++; if (fwd_valid_o !== exp_fv || fwd_data_o !== exp_fd)
                begin n_fail++; $display("FAIL load_fwd[%0d] got %0b/%h want %0b/%h", i, fwd_valid_o, fwd_data_o, exp_fv, exp_fd); end
            @(posedge clk);
            #1;
            lsu_valid_i = 1'b0;
            n_tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'(10 + i) || rd_data_o !== exp[i])
                begin n_fail++; $display("FAIL load_ext[%0d] got we=%0b a=%0d d=%h want 1/%0d/%h", i, rd_we_o, rd_addr_o, rd_data_o, 10 + i, exp[i]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_x0;
        @(negedge clk);
        ex_valid_i   = 1'b1;
        ex_rd_we_i   = 1'b1;
        ex_rd_addr_i = 5'd0;
        ex_rd_data_i = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %0b want 1", ex_ready_o); end
        @(posedge clk);
        #1;
        n_tests++; if (rd_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we got %0b want 0", rd_we_o); end
        n_tests++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL x0_busy got %h want 0", busy_o); end
        ex_rd_we_i   = 1'b0;
        ex_rd_addr_i = 5'd9;
        ex_rd_data_i = 32'h0000_0999;
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        n_tests++; if (rd_we_o !== 1'b0) begin n_fail++; $display("FAIL nowe_we got %0b want 0", rd_we_o); end
    endtask

    task automatic test_set_wins;
        do_issue(5'd7);
        @(negedge clk);
        ex_valid_i   = 1'b1;
        ex_rd_we_i   = 1'b1;
        ex_rd_addr_i = 5'd7;
        ex_rd_data_i = 32'h0000_0077;
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        issue_we_i = 1'b1;
        issue_rd_i = 5'd7;
        n_tests++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd7)
            begin n_fail++; $display("FAIL setwin_commit got we=%0b a=%0d want 1/7", rd_we_o, rd_addr_o); end
        @(posedge clk);
        #1;
        issue_we_i = 1'b0;
        n_tests++; if (busy_o !== 32'h0000_0080) begin n_fail++; $display("FAIL setwin_busy got %h want 00000080", busy_o); end
    endtask

    task automatic test_reset_mid;
        do_issue(5'd5);
        n_tests++; if (busy_o !== 32'h0000_00A0) begin n_fail++; $display("FAIL rstmid_busy_pre got %h want 000000a0", busy_o); end
        @(negedge clk);
        ex_valid_i   = 1'b1;
        ex_rd_we_i   = 1'b1;
        ex_rd_addr_i = 5'd5;
        ex_rd_data_i = 32'h0000_0055;
        @(posedge clk);
        #1;
        ex_valid_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        n_tests++; if (rd_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_we got %0b want 0", rd_we_o); end
        n_tests++; if (busy_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_busy got %h want 0", busy_o); end
        @(posedge clk);
        #1;
        n_tests++; if (rd_we_o !== 1'b0 || lsu_ready_o !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_hold got we=%0b rdy=%0b want 0/0", rd_we_o, lsu_ready_o); end
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rd_we_o !== 1'b0 || busy_o !== 32'h0)
            begin n_fail++; $display("FAIL rstmid_after got we=%0b busy=%h want 0/0", rd_we_o, busy_o); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_ex_commit();
        test_arbitration();
        test_load_ext();
        test_x0();
        test_set_wins();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_commit
`default_nettype wire
